// File: rtl/async_pkg.sv
// rtl/async_pkg.sv - shared types and defaults for the async sink bridge
package async_pkg;

  typedef enum logic {IDLE, ACK} async_sink_state_t;

  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_ff_m.sv
// rtl/sync_ff_m.sv - N-flop reset-to-zero single-bit synchronizer
module sync_ff_m #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] stage_q;
  logic [N-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[N-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[N-1];

endmodule

// File: rtl/async_sink_bridge_m.sv
// rtl/async_sink_bridge_m.sv - 4-phase bundled-data sink into a clocked valid/ready FIFO
// Optional handshake timeout with sticky err: define ASYNC_SINK_TIMEOUT_EN.
module async_sink_bridge_m
  import async_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 4,
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_req,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ack,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  logic req_s;

  sync_ff_m #(.N(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_req),
    .q     (req_s)
  );

  async_sink_state_t state_q, state_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              pend_q, pend_d;
  logic              wr_en;
  logic              pop;
  logic              full;

  // A captured word becomes visible to the consumer one clock after capture;
  // pend_q still occupies its slot so the full check must include it.
  always_comb begin
    full    = ({1'b0, count_q} + {{CW{1'b0}}, pend_q}) >= (CW+1)'(DEPTH);
    pop     = (count_q != '0) && out_ready;
    state_d = state_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s && !full) begin
          wr_en   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    wptr_d  = wptr_q + AW'(wr_en);
    rptr_d  = rptr_q + AW'(pop);
    pend_d  = wr_en;
    count_d = count_q;
    case ({pend_q, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= in_data;
    end
  end

  assign in_ack    = (state_q == ACK);
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rptr_q];
  assign count     = count_q;

`ifdef ASYNC_SINK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  always_comb begin
    tmo_d = tmo_q;
    err_d = err_q;
    if (state_q == IDLE && state_d == ACK) begin
      tmo_d = '0;
    end else if (state_q == ACK && tmo_q != TW'(TIMEOUT_CYCLES)) begin
      tmo_d = tmo_q + TW'(1);
    end
    if (state_q == ACK && tmo_d == TW'(TIMEOUT_CYCLES)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
